// File: rtl/castor32rv_run_ctrl.sv
// Run-control unit for the castor32rv core: drives a single clock-enable for halt, free-run,
// N-cycle single-step and PC breakpoints, and counts retired cycles.
module castor32rv_run_ctrl #(
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned NUM_BREAKPOINTS = 4,
  parameter int unsigned CYCLE_CNT_WIDTH = 32,
  parameter int unsigned STEP_CNT_WIDTH  = 16,
  localparam int unsigned BPW = (NUM_BREAKPOINTS > 1) ? $clog2(NUM_BREAKPOINTS) : 1
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       cmd_valid_i,
  output logic                       cmd_ready_o,
  input  logic [2:0]                 cmd_op_i,
  input  logic [ADDR_WIDTH-1:0]      cmd_arg_i,
  input  logic [BPW-1:0]             cmd_bp_idx_i,
  input  logic [ADDR_WIDTH-1:0]      pc_addr_i,
  output logic                       core_en_o,
  output logic                       halted_o,
  output logic [1:0]                 halt_reason_o,
  output logic [BPW-1:0]             bp_hit_idx_o,
  output logic [CYCLE_CNT_WIDTH-1:0] cycles_o,
  output logic                       halt_pulse_o
);

  localparam logic [2:0] OpHalt      = 3'd1;
  localparam logic [2:0] OpRun       = 3'd2;
  localparam logic [2:0] OpStep      = 3'd3;
  localparam logic [2:0] OpSetBp     = 3'd4;
  localparam logic [2:0] OpClrBp     = 3'd5;
  localparam logic [2:0] OpClrCycles = 3'd6;

  localparam logic [1:0] ReasonCmd  = 2'd1;
  localparam logic [1:0] ReasonStep = 2'd2;
  localparam logic [1:0] ReasonBp   = 2'd3;

  typedef enum logic [1:0] {StHalt, StRun, StStep} state_e;

  state_e                     state_q, state_d;
  logic [1:0]                 reason_q, reason_d;
  logic [BPW-1:0]             bp_hit_q, bp_hit_d;
  logic [CYCLE_CNT_WIDTH-1:0] cycles_q, cycles_d;
  logic [STEP_CNT_WIDTH-1:0]  step_q, step_d;
  logic                       skip_q, skip_d;
  logic                       pulse_q, pulse_d;
  logic [NUM_BREAKPOINTS-1:0] bp_valid_q;
  logic [ADDR_WIDTH-1:0]      bp_addr_q [NUM_BREAKPOINTS];

  logic           cmd_acc;
  logic           bp_match;
  logic [BPW-1:0] bp_idx;
  logic           bp_block;

  // Scan downwards so the lowest matching slot wins.
  always_comb begin
    bp_match = 1'b0;
    bp_idx   = '0;
    for (int i = NUM_BREAKPOINTS - 1; i >= 0; i--) begin
      if (bp_valid_q[i] && (bp_addr_q[i] == pc_addr_i)) begin
        bp_match = 1'b1;
        bp_idx   = BPW'(i);
      end
    end
  end

  assign bp_block = bp_match && !skip_q;
  assign cmd_acc  = cmd_valid_i && cmd_ready_o;

  always_comb begin
    cmd_ready_o = (state_q == StHalt) || !((cmd_op_i == OpRun) || (cmd_op_i == OpStep));
    core_en_o   = (state_q != StHalt) && !bp_block;
    halted_o    = (state_q == StHalt);
  end

  always_comb begin
    state_d  = state_q;
    reason_d = reason_q;
    bp_hit_d = bp_hit_q;
    step_d   = step_q;
    skip_d   = skip_q;
    pulse_d  = 1'b0;
    unique case (state_q)
      StHalt: begin
        if (cmd_acc && (cmd_op_i == OpRun)) begin
          state_d = StRun;
          skip_d  = 1'b1;
        end else if (cmd_acc && (cmd_op_i == OpStep)) begin
          state_d = StStep;
          skip_d  = 1'b1;
          step_d  = (cmd_arg_i[STEP_CNT_WIDTH-1:0] == '0) ? STEP_CNT_WIDTH'(1)
                                                          : cmd_arg_i[STEP_CNT_WIDTH-1:0];
        end
      end
      StRun, StStep: begin
        if (core_en_o) begin
          skip_d = 1'b0;
          if (state_q == StStep) step_d = step_q - STEP_CNT_WIDTH'(1);
        end
        if (bp_block) begin
          state_d  = StHalt;
          reason_d = ReasonBp;
          bp_hit_d = bp_idx;
          pulse_d  = 1'b1;
        end else if ((state_q == StStep) && core_en_o && (step_q == STEP_CNT_WIDTH'(1))) begin
          state_d  = StHalt;
          reason_d = ReasonStep;
          pulse_d  = 1'b1;
        end else if (cmd_acc && (cmd_op_i == OpHalt)) begin
          state_d  = StHalt;
          reason_d = ReasonCmd;
          pulse_d  = 1'b1;
        end
      end
      default: state_d = StHalt;
    endcase

    cycles_d = cycles_q;
    if (cmd_acc && (cmd_op_i == OpClrCycles)) begin
      cycles_d = '0;
    end else if (core_en_o && (cycles_q != '1)) begin
      cycles_d = cycles_q + CYCLE_CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= StHalt;
      reason_q <= '0;
      bp_hit_q <= '0;
      cycles_q <= '0;
      step_q   <= '0;
      skip_q   <= 1'b0;
      pulse_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      reason_q <= reason_d;
      bp_hit_q <= bp_hit_d;
      cycles_q <= cycles_d;
      step_q   <= step_d;
      skip_q   <= skip_d;
      pulse_q  <= pulse_d;
    end
  end

  // Out-of-range slot indices match no slot and are dropped.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bp_valid_q <= '0;
    end else if (cmd_acc) begin
      for (int i = 0; i < NUM_BREAKPOINTS; i++) begin
        if (cmd_bp_idx_i == BPW'(i)) begin
          if (cmd_op_i == OpSetBp) begin
            bp_valid_q[i] <= 1'b1;
            bp_addr_q[i]  <= cmd_arg_i;
          end else if (cmd_op_i == OpClrBp) begin
            bp_valid_q[i] <= 1'b0;
          end
        end
      end
    end
  end

  assign halt_reason_o = reason_q;
  assign bp_hit_idx_o  = bp_hit_q;
  assign cycles_o      = cycles_q;
  assign halt_pulse_o  = pulse_q;

endmodule

// File: tb/tb_castor32rv_run_ctrl.sv
// Directed bench for castor32rv_run_ctrl; a second narrow-counter instance shares the stimulus
// so counter saturation can be reached in a few cycles.
module tb_castor32rv_run_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic [2:0]  cmd_op;
  logic [31:0] cmd_arg;
  logic [1:0]  cmd_bp_idx;
  logic [31:0] pc;

  logic        cmd_ready, core_en, halted, halt_pulse;
  logic [1:0]  halt_reason, bp_hit_idx;
  logic [31:0] cycles;

  logic        s_cmd_ready, s_core_en, s_halted, s_halt_pulse;
  logic [1:0]  s_halt_reason, s_bp_hit_idx;
  logic [3:0]  s_cycles;

  int n_chk  = 0;
  int n_fail = 0;
  int en_cnt, pulse_cnt, k;
  logic en_at_bp;

  localparam logic [2:0] NOP = 0, HALT = 1, RUN = 2, STEP = 3, SET_BP = 4, CLR_BP = 5, CLR_CYC = 6;

  always #5 clk = ~clk;

  castor32rv_run_ctrl dut (
    .clk_i(clk), .rst_i(rst), .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .cmd_op_i(cmd_op), .cmd_arg_i(cmd_arg), .cmd_bp_idx_i(cmd_bp_idx), .pc_addr_i(pc),
    .core_en_o(core_en), .halted_o(halted), .halt_reason_o(halt_reason),
    .bp_hit_idx_o(bp_hit_idx), .cycles_o(cycles), .halt_pulse_o(halt_pulse)
  );

  castor32rv_run_ctrl #(.CYCLE_CNT_WIDTH(4)) dut_sat (
    .clk_i(clk), .rst_i(rst), .cmd_valid_i(cmd_valid), .cmd_ready_o(s_cmd_ready),
    .cmd_op_i(cmd_op), .cmd_arg_i(cmd_arg), .cmd_bp_idx_i(cmd_bp_idx), .pc_addr_i(pc),
    .core_en_o(s_core_en), .halted_o(s_halted), .halt_reason_o(s_halt_reason),
    .bp_hit_idx_o(s_bp_hit_idx), .cycles_o(s_cycles), .halt_pulse_o(s_halt_pulse)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_cmd(input logic [2:0] op, input logic [31:0] arg, input logic [1:0] idx);
    cmd_valid  = 1'b1;
    cmd_op     = op;
    cmd_arg    = arg;
    cmd_bp_idx = idx;
    tick();
    cmd_valid  = 1'b0;
    cmd_op     = NOP;
  endtask

  // Count enable and pulse cycles over a fixed window with a static PC.
  task automatic count_window(input int n);
    en_cnt    = 0;
    pulse_cnt = 0;
    for (int i = 0; i < n; i++) begin
      if (core_en) en_cnt++;
      if (halt_pulse) pulse_cnt++;
      tick();
    end
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = NOP; cmd_arg = '0; cmd_bp_idx = '0; pc = '0;
    tick(); tick();
    rst = 1'b0;
    repeat (5) tick();
    chk("reset_halted", halted, 1);
    chk("reset_core_en", core_en, 0);
    chk("reset_cycles", cycles, 0);
    chk("reset_reason", halt_reason, 0);
    chk("reset_ready", cmd_ready, 1);
    chk("reset_pulse", halt_pulse, 0);

    // STEP 3 then STEP 0
    do_cmd(STEP, 3, 0);
    count_window(8);
    chk("step3_en_cycles", en_cnt, 3);
    chk("step3_pulses", pulse_cnt, 1);
    chk("step3_halted", halted, 1);
    chk("step3_reason", halt_reason, 2);
    chk("step3_cycles", cycles, 3);
    do_cmd(STEP, 0, 0);
    count_window(6);
    chk("step0_en_cycles", en_cnt, 1);
    chk("step0_cycles", cycles, 4);

    // HALT while halted changes nothing
    do_cmd(HALT, 0, 0);
    chk("halt_in_halt_reason", halt_reason, 2);
    chk("halt_in_halt_pulse", halt_pulse, 0);

    // Breakpoint at 0x20 with a ramping PC
    do_cmd(SET_BP, 32'h20, 2);
    do_cmd(CLR_CYC, 0, 0);
    chk("clr_cycles_halt", cycles, 0);
    do_cmd(RUN, 0, 0);
    k = 0;
    en_at_bp = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (halted) break;
      pc = 32'(k * 4);
      #1;
      if (pc == 32'h20) en_at_bp = core_en;
      if (core_en) k++;
      tick();
    end
    chk("bp_core_en_at_bp", en_at_bp, 0);
    chk("bp_retired", k, 8);
    chk("bp_halted", halted, 1);
    chk("bp_reason", halt_reason, 3);
    chk("bp_hit_idx", bp_hit_idx, 2);
    chk("bp_cycles", cycles, 8);
    chk("bp_pulse", halt_pulse, 1);

    // Resume from the breakpoint: skip lets the first instruction go
    do_cmd(RUN, 0, 0);
    chk("resume_skip_en", core_en, 1);
    tick();
    pc = 32'h24;
    #1;
    chk("resume_continue_en", core_en, 1);
    tick();

    // CLR_CYCLES wins over the same-cycle increment
    do_cmd(CLR_CYC, 0, 0);
    chk("clr_cycles_run", cycles, 0);
    cmd_valid = 1'b1; cmd_op = RUN;
    #1;
    chk("run_while_running_ready", cmd_ready, 0);
    repeat (10) tick();
    chk("stalled_run_cycles", cycles, 10);
    cmd_op = HALT;
    #1;
    chk("halt_cmd_ready", cmd_ready, 1);
    tick();
    cmd_valid = 1'b0; cmd_op = NOP;
    chk("halt_cmd_cycles", cycles, 11);
    chk("halt_cmd_reason", halt_reason, 1);
    chk("halt_cmd_pulse", halt_pulse, 1);

    // STEP 2 with a breakpoint on the second PC; two slots match, lowest wins
    do_cmd(SET_BP, 32'h44, 3);
    do_cmd(SET_BP, 32'h44, 1);
    do_cmd(CLR_CYC, 0, 0);
    pc = 32'h40;
    do_cmd(STEP, 2, 0);
    chk("stepbp_first_en", core_en, 1);
    tick();
    pc = 32'h44;
    #1;
    chk("stepbp_blocked", core_en, 0);
    tick();
    chk("stepbp_reason", halt_reason, 3);
    chk("stepbp_idx", bp_hit_idx, 1);
    chk("stepbp_cycles", cycles, 1);

    // HALT coincident with last step: step done wins; cleared slots no longer match
    do_cmd(CLR_BP, 0, 1);
    do_cmd(CLR_BP, 0, 3);
    do_cmd(CLR_CYC, 0, 0);
    do_cmd(STEP, 2, 0);
    tick();
    chk("clrbp_no_block", core_en, 1);
    do_cmd(HALT, 0, 0);
    chk("step_vs_halt_reason", halt_reason, 2);
    chk("step_vs_halt_halted", halted, 1);
    chk("step_vs_halt_cycles", cycles, 2);

    // Reset mid-RUN clears state and breakpoints
    do_cmd(SET_BP, 32'h80, 0);
    pc = 32'h50;
    do_cmd(RUN, 0, 0);
    tick();
    chk("pre_reset_en", core_en, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_core_en", core_en, 0);
    chk("midrst_halted", halted, 1);
    chk("midrst_cycles", cycles, 0);
    chk("midrst_reason", halt_reason, 0);
    pc = 32'h80;
    do_cmd(RUN, 0, 0);
    tick();
    chk("midrst_bp_cleared", core_en, 1);
    repeat (19) tick();
    do_cmd(HALT, 0, 0);
    chk("long_run_cycles", cycles, 21);
    chk("saturate_narrow", s_cycles, 15);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/castor32rv_run_ctrl.md
Name: castor32rv_run_ctrl

Overview:
Synthesizable run-control unit that gates the castor32rv core through a single clock-enable. It provides halt, free-run, N-cycle single-step and up to NUM_BREAKPOINTS PC breakpoints, plus a retired-cycle counter. It sits between the host/debug command source and the core's pc_addr, and replaces file-driven clock stepping with on-chip control.

Parameters:
ADDR_WIDTH, 32, width of pc_addr and breakpoint addresses
NUM_BREAKPOINTS, 4, number of PC breakpoint comparators (≥1)
CYCLE_CNT_WIDTH, 32, width of retired-cycle counter
STEP_CNT_WIDTH, 16, width of step count taken from cmd_arg[STEP_CNT_WIDTH-1:0]

Ports:
clk  in  1  single clock
rst  in  1  synchronous, active-high reset
cmd_valid  in  1  command present
cmd_ready  out  1  command accepted when cmd_valid && cmd_ready at rising clk
cmd_op  in  3  0 NOP, 1 HALT, 2 RUN, 3 STEP, 4 SET_BP, 5 CLR_BP, 6 CLR_CYCLES
cmd_arg  in  ADDR_WIDTH  step count (STEP) or breakpoint address (SET_BP)
cmd_bp_idx  in  BPW=max(1,$clog2(NUM_BREAKPOINTS))  breakpoint slot for SET_BP/CLR_BP
pc_addr  in  ADDR_WIDTH  current core PC
core_en  out  1  core clock-enable; one instruction retires per cycle high
halted  out  1  state == HALT
halt_reason  out  2  0 reset, 1 command, 2 step done, 3 breakpoint
bp_hit_idx  out  BPW  lowest-index breakpoint that caused the last halt
cycles  out  CYCLE_CNT_WIDTH  count of core_en-high cycles
halt_pulse  out  1  one-cycle pulse on the cycle after entering HALT

Behaviour:
- States: HALT, RUN, STEP. All state is updated on rising clk only.
- Reset (rst=1 at edge): state HALT; core_en 0; halted 1; halt_reason 0; bp_hit_idx 0; cycles 0; all breakpoint slots invalid; step counter 0; skip flag 0; halt_pulse 0.
- Mid-operation reset has the same effect, with no residual core_en.
- cmd_ready (combinational):
  - 1 in HALT.
  - In RUN/STEP: 1 for ops 0, 1, 4, 5, 6 and undefined ops 7; 0 for RUN/STEP, which stall until HALT.
- Undefined op 7 is treated as NOP.
- bp_match (combinational): any valid slot with addr == pc_addr; lowest matching index is reported.
- bp_block = bp_match && !skip.
- core_en (combinational) = (state == RUN || state == STEP) && !bp_block.
- Entering RUN or STEP from HALT sets skip=1, so the instruction at a resumed breakpoint executes. skip clears after the first core_en cycle.
- RUN accepted in HALT: next state RUN. Execution continues until a halt condition.
- STEP accepted in HALT: step_cnt = arg[STEP_CNT_WIDTH-1:0]; a value of 0 is treated as 1. Next state STEP.
  - Each core_en cycle decrements step_cnt.
  - When core_en && step_cnt == 1: next state HALT, reason 2.
- Halt priority in one cycle: breakpoint (bp_block) > step done > HALT command.
  - bp_block in RUN/STEP: next state HALT, reason 3, bp_hit_idx latched. core_en is 0 in that cycle.
  - HALT command accepted in RUN/STEP: next state HALT, reason 1. core_en in the accept cycle still follows the current state.
  - HALT command while already in HALT: no state change, halt_reason unchanged, no halt_pulse.
- halt_pulse = 1 for exactly one cycle after any RUN/STEP→HALT transition.
- SET_BP: slot[idx] ← {valid=1, addr=arg}. CLR_BP: slot[idx].valid ← 0. Both take effect from the next cycle. An idx ≥ NUM_BREAKPOINTS is ignored.
- cycles:
  - Increments by 1 on each core_en cycle and saturates at all-ones.
  - CLR_CYCLES sets cycles to 0 and wins over a same-cycle increment.
- halt_reason and bp_hit_idx hold until the next halt entry or reset.

Test Plan:
- Reset then idle 5 cycles → halted=1, core_en=0, cycles=0, halt_reason=0, cmd_ready=1.
- STEP arg=3 from HALT → core_en high exactly 3 cycles; then halted=1, halt_reason=2, cycles=3, halt_pulse 1 cycle; STEP arg=0 → exactly 1 core_en cycle.
- SET_BP idx=2 addr=0x20, RUN, pc_addr ramps 0x00,0x04,… → core_en=0 when pc=0x20, halt_reason=3, bp_hit_idx=2, cycles=8; RUN again with pc=0x20 → one core_en cycle (skip), then continues.
- RUN, then HALT command after 10 cycles → cycles=10 or 11 per accept-cycle rule (=11 counting the accept cycle), halt_reason=1; RUN issued while running → cmd_ready=0 until HALT.
- STEP arg=2 with breakpoint at second PC → breakpoint wins: halt_reason=3, cycles=1; HALT command coincident with final step → halt_reason=2.
- CLR_CYCLES during RUN → cycles=0 that edge then resumes counting; assert rst mid-RUN → core_en=0 next cycle, breakpoints cleared; cycles preset near all-ones saturates, no wrap.
